result_collector: RTL and testbench

RESULT_COLLECTOR -- requirements
Module: result_collector

---
 rtl/matrix_pkg.sv | 21 ++
 rtl/row_fifo.sv | 71 +++++++
 rtl/result_collector.sv | 83 ++++++++
 tb/tb_result_collector.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and helpers for the result-matrix collector.
package matrix_pkg;

    // Index width that never collapses to zero bits, even for a single-entry range.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int unsigned DefaultSize      = 2;
    localparam int unsigned DefaultCellWidth = 32;
    localparam int unsigned DefaultFifoDepth = 2;
    localparam int unsigned DefaultRowWidth  = DefaultSize * DefaultCellWidth;
    localparam int unsigned DefaultIdxWidth  = idx_width(DefaultSize);

    // Encoding chosen so that the acknowledge output is the state bit itself.
    typedef enum logic {
        StWait = 1'b0,
        StAck  = 1'b1
    } in_state_e;

endpackage

// File: rtl/row_fifo.sv
// Small FIFO of completed rows, each carrying a "last row of matrix" tag.
module row_fifo
    import matrix_pkg::*;
#(
    parameter int unsigned Depth     = DefaultFifoDepth,
    parameter int unsigned DataWidth = DefaultRowWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 push_i,
    input  logic [DataWidth-1:0] push_data_i,
    input  logic                 push_last_i,
    input  logic                 pop_i,
    output logic [DataWidth-1:0] data_o,
    output logic                 last_o,
    output logic                 full_o,
    output logic                 empty_o
);

    localparam int unsigned PtrWidth = idx_width(Depth);
    localparam int unsigned CntWidth = $clog2(Depth + 1);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(Depth - 1);

    logic [DataWidth-1:0] mem_q  [Depth];
    logic                 last_q [Depth];
    logic [PtrWidth-1:0]  wr_q, rd_q;
    logic [CntWidth-1:0]  cnt_q;
    logic                 do_push, do_pop;

    function automatic logic [PtrWidth-1:0] next_ptr(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    // Status flags and head presentation; an empty FIFO shows an all-zero head.
    always_comb begin
        full_o  = (cnt_q == CntWidth'(Depth));
        empty_o = (cnt_q == '0);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        data_o  = empty_o ? '0 : mem_q[rd_q];
        last_o  = empty_o ? 1'b0 : last_q[rd_q];
    end

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i]  <= '0;
                last_q[i] <= 1'b0;
            end
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_q]  <= push_data_i;
                last_q[wr_q] <= push_last_i;
                wr_q         <= next_ptr(wr_q);
            end
            if (do_pop) begin
                rd_q <= next_ptr(rd_q);
            end
            unique case ({do_push, do_pop})
                2'b10:   cnt_q <= cnt_q + CntWidth'(1);
                2'b01:   cnt_q <= cnt_q - CntWidth'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/result_collector.sv
// Collects result cells from the column processor into rows and queues them downstream.
module result_collector
    import matrix_pkg::*;
#(
    parameter int unsigned size       = DefaultSize,
    parameter int unsigned cell_width = DefaultCellWidth,
    parameter int unsigned fifo_depth = DefaultFifoDepth
) (
    input  logic                         in_clk,
    input  logic                         in_reset,
    input  logic                         in_ready,
    input  logic [cell_width-1:0]        in_cell_c,
    output logic                         out_ack,
    output logic [size*cell_width-1:0]   out_row_c,
    output logic                         out_row_valid,
    input  logic                         in_row_ack,
    output logic                         out_row_last
);

    localparam int unsigned RowWidth = size * cell_width;
    localparam int unsigned IdxWidth = idx_width(size);
    localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(size - 1);

    in_state_e             state_q;
    logic [IdxWidth-1:0]   col_q, row_q;
    logic [RowWidth-1:0]   partial_q;
    logic [RowWidth-1:0]   row_assembled;
    logic                  row_done, capture, push;
    logic                  fifo_full, fifo_empty;

    // Capture gating and row assembly; the first cell lands in the most significant slot.
    always_comb begin
        row_done      = (col_q == LastIdx);
        // Uses the registered full flag, so a pop on this edge cannot admit the push.
        capture       = (state_q == StWait) && in_ready && !(row_done && fifo_full);
        push          = capture && row_done;
        row_assembled = partial_q;
        row_assembled[(int'(size) - 1 - int'(col_q)) * int'(cell_width) +: cell_width] = in_cell_c;
    end

    // Input handshake FSM together with column/row counters and the partial row.
    always_ff @(posedge in_clk or negedge in_reset) begin
        if (!in_reset) begin
            state_q   <= StWait;
            col_q     <= '0;
            row_q     <= '0;
            partial_q <= '0;
        end else begin
            unique case (state_q)
                StWait:  if (capture)   state_q <= StAck;
                StAck:   if (!in_ready) state_q <= StWait;
                default: state_q <= StWait;
            endcase
            if (capture) begin
                partial_q <= row_assembled;
                col_q     <= row_done ? '0 : col_q + IdxWidth'(1);
            end
            if (push) begin
                row_q <= (row_q == LastIdx) ? '0 : row_q + IdxWidth'(1);
            end
        end
    end

    assign out_ack       = (state_q == StAck);
    assign out_row_valid = !fifo_empty;

    row_fifo #(
        .Depth     (fifo_depth),
        .DataWidth (RowWidth)
    ) u_row_fifo (
        .clk_i       (in_clk),
        .rst_ni      (in_reset),
        .push_i      (push),
        .push_data_i (row_assembled),
        .push_last_i (row_q == LastIdx),
        .pop_i       (in_row_ack),
        .data_o      (out_row_c),
        .last_o      (out_row_last),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

endmodule

// File: tb/tb_result_collector.sv
// Scoreboard bench for result_collector: stimulus queues expected rows, a monitor checks pops.
module tb_result_collector;

    localparam int unsigned Size  = 2;
    localparam int unsigned CellW = 32;
    localparam int unsigned RowW  = Size * CellW;

    logic              in_clk     = 1'b0;
    logic              in_reset   = 1'b0;
    logic              in_ready   = 1'b0;
    logic [CellW-1:0]  in_cell_c  = '0;
    logic              in_row_ack = 1'b0;
    logic              out_ack;
    logic [RowW-1:0]   out_row_c;
    logic              out_row_valid;
    logic              out_row_last;

    typedef struct packed {
        logic [RowW-1:0] data;
        logic            last;
    } row_t;

    row_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    result_collector #(
        .size       (Size),
        .cell_width (CellW),
        .fifo_depth (2)
    ) dut (
        .in_clk        (in_clk),
        .in_reset      (in_reset),
        .in_ready      (in_ready),
        .in_cell_c     (in_cell_c),
        .out_ack       (out_ack),
        .out_row_c     (out_row_c),
        .out_row_valid (out_row_valid),
        .in_row_ack    (in_row_ack),
        .out_row_last  (out_row_last)
    );

    always #5 in_clk = ~in_clk;

    task automatic chk(input logic [127:0] act, input logic [127:0] exp, input string name);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    task automatic wait_ack(input logic v, input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (out_ack !== v && n < 20);
        chk(out_ack, v, name);
    endtask

    task automatic send_cell(input logic [CellW-1:0] c);
        in_ready  = 1'b1;
        in_cell_c = c;
        wait_ack(1'b1, "ack_rise");
        in_ready  = 1'b0;
        wait_ack(1'b0, "ack_fall");
    endtask

    task automatic pop_rows(input int n);
        in_row_ack = 1'b1;
        repeat (n) tick();
        in_row_ack = 1'b0;
    endtask

    // Monitor: every head row consumed downstream is compared against the scoreboard.
    always @(negedge in_clk) begin
        row_t e;
        if (in_reset && out_row_valid && in_row_ack) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: actual=%0h required=none", out_row_c);
            end else begin
                e = exp_q.pop_front();
                chk(out_row_c, e.data, "row_data");
                chk(out_row_last, e.last, "row_last");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset state
        repeat (3) tick();
        chk(out_ack, 1'b0, "reset_ack");
        chk(out_row_valid, 1'b0, "reset_valid");
        chk(out_row_last, 1'b0, "reset_last");
        chk(out_row_c, '0, "reset_row");
        in_reset = 1'b1;
        tick();

        // First row, including one-edge latency to out_row_valid
        exp_q.push_back(row_t'{data: 64'h3F80000040000000, last: 1'b0});
        send_cell(32'h3F800000);
        chk(out_row_valid, 1'b0, "valid_before_row_end");
        in_ready  = 1'b1;
        in_cell_c = 32'h40000000;
        tick();
        chk(out_ack, 1'b1, "ack_on_row_end");
        chk(out_row_valid, 1'b1, "valid_latency");
        in_ready = 1'b0;
        wait_ack(1'b0, "ack_fall");
        chk(out_row_c, 64'h3F80000040000000, "row0_head");
        chk(out_row_last, 1'b0, "row0_last");

        // Second row is the last row of the matrix
        exp_q.push_back(row_t'{data: 64'h4040000040800000, last: 1'b1});
        send_cell(32'h40400000);
        send_cell(32'h40800000);
        pop_rows(1);
        chk(out_row_valid, 1'b1, "row1_valid");
        chk(out_row_last, 1'b1, "row1_last");
        chk(out_row_c, 64'h4040000040800000, "row1_head");
        pop_rows(1);
        chk(out_row_valid, 1'b0, "empty_after_pops");

        // in_ready held for five edges captures a single cell
        exp_q.push_back(row_t'{data: 64'h1111111122222222, last: 1'b0});
        in_ready  = 1'b1;
        in_cell_c = 32'h11111111;
        chk(out_ack, 1'b0, "ack_before_capture");
        for (int i = 0; i < 5; i++) begin
            tick();
            chk(out_ack, 1'b1, "ack_held");
        end
        in_ready = 1'b0;
        tick();
        chk(out_ack, 1'b0, "ack_drop_after_ready_low");
        send_cell(32'h22222222);
        pop_rows(1);

        // Full FIFO blocks the completing cell until one edge after a pop
        exp_q.push_back(row_t'{data: 64'hAAAA0001BBBB0002, last: 1'b1});
        exp_q.push_back(row_t'{data: 64'hCCCC0003DDDD0004, last: 1'b0});
        exp_q.push_back(row_t'{data: 64'hEEEE0005FFFF0006, last: 1'b1});
        send_cell(32'hAAAA0001);
        send_cell(32'hBBBB0002);
        send_cell(32'hCCCC0003);
        send_cell(32'hDDDD0004);
        send_cell(32'hEEEE0005);
        chk(out_row_valid, 1'b1, "full_valid");
        in_ready  = 1'b1;
        in_cell_c = 32'hFFFF0006;
        repeat (3) begin
            tick();
            chk(out_ack, 1'b0, "ack_blocked_full");
        end
        in_row_ack = 1'b1;
        tick();
        in_row_ack = 1'b0;
        chk(out_ack, 1'b0, "no_same_cycle_unblock");
        tick();
        chk(out_ack, 1'b1, "capture_after_pop");
        in_ready = 1'b0;
        wait_ack(1'b0, "ack_fall");
        pop_rows(2);
        chk(out_row_valid, 1'b0, "empty_after_drain");

        // Acknowledge with an empty FIFO is ignored
        in_row_ack = 1'b1;
        repeat (2) begin
            tick();
            chk(out_row_valid, 1'b0, "empty_ack_valid");
            chk(out_row_c, '0, "empty_ack_row");
            chk(out_row_last, 1'b0, "empty_ack_last");
        end
        in_row_ack = 1'b0;

        // Reset with a queued row and a partial row discards both
        exp_q.push_back(row_t'{data: 64'h40A0000040C00000, last: 1'b0});
        send_cell(32'h40A00000);
        send_cell(32'h40C00000);
        send_cell(32'h41000000);
        in_reset = 1'b0;
        exp_q.delete();
        #1;
        chk(out_ack, 1'b0, "midreset_ack");
        chk(out_row_valid, 1'b0, "midreset_valid");
        chk(out_row_last, 1'b0, "midreset_last");
        chk(out_row_c, '0, "midreset_row");
        in_ready  = 1'b1;
        in_cell_c = 32'h41200000;
        tick();
        tick();
        exp_q.push_back(row_t'{data: 64'h4120000041A00000, last: 1'b0});
        in_reset = 1'b1;
        wait_ack(1'b1, "held_ready_capture");
        in_ready = 1'b0;
        wait_ack(1'b0, "ack_fall");
        send_cell(32'h41A00000);
        chk(out_row_valid, 1'b1, "post_reset_valid");
        chk(out_row_last, 1'b0, "post_reset_last");
        chk(out_row_c, 64'h4120000041A00000, "post_reset_row");
        pop_rows(1);

        chk(exp_q.size(), 0, "scoreboard_drained");
        chk(out_row_valid, 1'b0, "final_empty");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
